// File: rtl/rx_byte_asm_50_pkg.sv
// rx_pkg: shared types and constants for the serial receive front end.
//   HDR_TEMP_C / HDR_CHECK_C : default header byte values.
//   rx_byte_t                : one assembled byte.
//   rx_pkt_state_t           : packet tracker state (IDLE, PAYLOAD).
//   rx_is_hdr()              : true when a byte matches either header value.
package rx_pkg;

  localparam logic [7:0] HDR_TEMP_C  = 8'hA5;
  localparam logic [7:0] HDR_CHECK_C = 8'hC3;

  typedef logic [7:0] rx_byte_t;

  typedef enum logic {
    IDLE,
    PAYLOAD
  } rx_pkt_state_t;

  function automatic logic rx_is_hdr(input rx_byte_t b,
                                     input rx_byte_t hdr_temp,
                                     input rx_byte_t hdr_check);
    return (b == hdr_temp) || (b == hdr_check);
  endfunction

endpackage

// File: rtl/rx_byte_asm_50_sync_edge.sv
// rx_sync_edge: STAGES-deep synchronizer for one asynchronous input, plus
// single-cycle rising/falling edge pulses of the synchronized level.
//   clk_i  : sampling clock
//   rst_ni : synchronous active-low reset (clears chain and edge history)
//   d_i    : asynchronous input
//   q_o    : synchronized level
//   rise_o : q_o went 0 -> 1 this cycle
//   fall_o : q_o went 1 -> 0 this cycle
module rx_sync_edge #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign q_o    = sync_q[STAGES-1];
  assign rise_o = q_o & ~prev_q;
  assign fall_o = ~q_o & prev_q;

endmodule

// File: rtl/rx_byte_asm_50.sv
// rx_byte_asm_50: samples a slow serial line (clk_2 / serial_data / data_ena)
// on clk_50, assembles bits MSB-first into bytes, tracks header/payload
// packet position and flags header bytes for the downstream control FSM.
//   clk_50      : system clock (only clock)
//   reset_n     : synchronous active-low reset
//   clk_2       : serial bit clock (async, synchronized internally)
//   serial_data : serial bit, valid at clk_2 rising edge (async)
//   data_ena    : frame enable (async)
//   byte_out    : last assembled byte, held until the next completes
//   byte_valid  : one-cycle strobe, byte_out is new
//   a5_or_c3    : with byte_valid, byte_out is a header value
//   pkt_temp    : most recent header was HDR_TEMP
//   byte_idx    : 0 = header/idle byte, 1..DATA_BYTES = payload position
//   frame_err   : one-cycle strobe, partial byte dropped or payload short
// Build option: define RX_HDR_FILTER_EN to suppress byte_valid for
// non-header bytes received while idle (byte_out still updates).
module rx_byte_asm_50
  import rx_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [7:0]  HDR_TEMP    = HDR_TEMP_C,
  parameter logic [7:0]  HDR_CHECK   = HDR_CHECK_C,
  parameter int unsigned DATA_BYTES  = 2
) (
  input  logic       clk_50,
  input  logic       reset_n,
  input  logic       clk_2,
  input  logic       serial_data,
  input  logic       data_ena,
  output logic [7:0] byte_out,
  output logic       byte_valid,
  output logic       a5_or_c3,
  output logic       pkt_temp,
  output logic [1:0] byte_idx,
  output logic       frame_err
);

  // Synchronized inputs and edges
  logic clk2_s, tick, unused_clk2_fall;
  logic ena_s, ena_fall, unused_ena_rise;
  logic [SYNC_STAGES-1:0] sd_sync_q;
  logic sd_s;

  rx_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_clk2 (
    .clk_i  (clk_50),
    .rst_ni (reset_n),
    .d_i    (clk_2),
    .q_o    (clk2_s),
    .rise_o (tick),
    .fall_o (unused_clk2_fall)
  );

  rx_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_ena (
    .clk_i  (clk_50),
    .rst_ni (reset_n),
    .d_i    (data_ena),
    .q_o    (ena_s),
    .rise_o (unused_ena_rise),
    .fall_o (ena_fall)
  );

  // Same depth as the clk_2 chain so the data bit lines up with its tick.
  always_ff @(posedge clk_50) begin
    if (!reset_n) begin
      sd_sync_q <= '0;
    end else begin
      sd_sync_q <= {sd_sync_q[SYNC_STAGES-2:0], serial_data};
    end
  end
  assign sd_s = sd_sync_q[SYNC_STAGES-1];

  // Registers
  rx_pkt_state_t state_q, state_d;
  logic [6:0]    sh_q, sh_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  rx_byte_t      byte_out_q, byte_out_d;
  logic          byte_valid_q, byte_valid_d;
  logic          a5_q, a5_d;
  logic          pkt_temp_q, pkt_temp_d;
  logic [1:0]    byte_idx_q, byte_idx_d;
  logic          frame_err_q, frame_err_d;

  rx_byte_t   shifted;
  logic       hdr;
  logic [1:0] idx_next;

  assign shifted  = {sh_q, sd_s};
  assign hdr      = rx_is_hdr(shifted, HDR_TEMP, HDR_CHECK);
  assign idx_next = byte_idx_q + 2'd1;

  always_ff @(posedge clk_50) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      sh_q         <= '0;
      bit_cnt_q    <= '0;
      byte_out_q   <= '0;
      byte_valid_q <= 1'b0;
      a5_q         <= 1'b0;
      pkt_temp_q   <= 1'b0;
      byte_idx_q   <= '0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      sh_q         <= sh_d;
      bit_cnt_q    <= bit_cnt_d;
      byte_out_q   <= byte_out_d;
      byte_valid_q <= byte_valid_d;
      a5_q         <= a5_d;
      pkt_temp_q   <= pkt_temp_d;
      byte_idx_q   <= byte_idx_d;
      frame_err_q  <= frame_err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    sh_d         = sh_q;
    bit_cnt_d    = bit_cnt_q;
    byte_out_d   = byte_out_q;
    byte_valid_d = 1'b0;
    a5_d         = 1'b0;
    pkt_temp_d   = pkt_temp_q;
    byte_idx_d   = byte_idx_q;
    frame_err_d  = 1'b0;

    if (tick && ena_s) begin
      sh_d      = shifted[6:0];
      bit_cnt_d = bit_cnt_q + 3'd1;
      if (bit_cnt_q == 3'd7) begin
        byte_out_d   = shifted;
        byte_valid_d = 1'b1;
        a5_d         = hdr;
        unique case (state_q)
          IDLE: begin
            byte_idx_d = '0;
            if (hdr) begin
              state_d    = PAYLOAD;
              pkt_temp_d = (shifted == HDR_TEMP);
            end
`ifdef RX_HDR_FILTER_EN
            byte_valid_d = hdr;
`endif
          end
          PAYLOAD: begin
            // Header values inside a payload are plain data.
            byte_idx_d = idx_next;
            if (idx_next == 2'(DATA_BYTES)) state_d = IDLE;
          end
          default: state_d = IDLE;
        endcase
      end
    end

    // Evaluated on the post-update counters so a byte finishing alongside
    // the enable drop is kept; partial byte and short payload share one pulse.
    if (ena_fall && ((bit_cnt_d != 3'd0) || (state_d == PAYLOAD))) begin
      bit_cnt_d   = '0;
      state_d     = IDLE;
      frame_err_d = 1'b1;
    end
  end

  assign byte_out   = byte_out_q;
  assign byte_valid = byte_valid_q;
  assign a5_or_c3   = a5_q;
  assign pkt_temp   = pkt_temp_q;
  assign byte_idx   = byte_idx_q;
  assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_rx_byte_asm_50.sv
// Self-checking bench for rx_byte_asm_50: directed packet scenarios followed
// by a randomized byte/partial/enable-drop sequence, checked against a
// packet-level reference model.
module tb_rx_byte_asm_50;

  localparam int unsigned SYNC_STAGES = 2;
  localparam int unsigned DATA_BYTES  = 2;
  localparam logic [7:0]  H_TEMP      = 8'hA5;
  localparam logic [7:0]  H_CHECK     = 8'hC3;

  logic       clk_50 = 1'b0;
  logic       reset_n, clk_2, serial_data, data_ena;
  logic [7:0] byte_out;
  logic       byte_valid, a5_or_c3, pkt_temp, frame_err;
  logic [1:0] byte_idx;

  rx_byte_asm_50 #(
    .SYNC_STAGES (SYNC_STAGES),
    .HDR_TEMP    (H_TEMP),
    .HDR_CHECK   (H_CHECK),
    .DATA_BYTES  (DATA_BYTES)
  ) dut (
    .clk_50      (clk_50),
    .reset_n     (reset_n),
    .clk_2       (clk_2),
    .serial_data (serial_data),
    .data_ena    (data_ena),
    .byte_out    (byte_out),
    .byte_valid  (byte_valid),
    .a5_or_c3    (a5_or_c3),
    .pkt_temp    (pkt_temp),
    .byte_idx    (byte_idx),
    .frame_err   (frame_err)
  );

  always #10 clk_50 = ~clk_50;

  typedef struct {
    logic [7:0] b;
    logic       a5;
    logic       pt;
    logic [1:0] idx;
  } ev_t;

  ev_t evq[$];
  int  fe_cnt   = 0;
  int  n_assert = 0;
  int  n_fail   = 0;

  // Reference model state: payload bytes still owed, bits of an unfinished byte.
  int   m_remaining = 0;
  int   m_bits      = 0;
  logic m_pt        = 1'b0;

  always @(negedge clk_50) begin
    if (byte_valid) evq.push_back('{b: byte_out, a5: a5_or_c3, pt: pkt_temp, idx: byte_idx});
    if (frame_err) fe_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_byte(input logic [7:0] b, output logic ev, output logic ea,
                            output logic ep, output logic [1:0] ei);
    logic is_hdr;
    is_hdr = (b == H_TEMP) || (b == H_CHECK);
    if (m_remaining == 0) begin
      ei = 2'd0;
      ea = is_hdr;
      if (is_hdr) begin
        m_remaining = DATA_BYTES;
        m_pt        = (b == H_TEMP);
        ev          = 1'b1;
      end else begin
`ifdef RX_HDR_FILTER_EN
        ev = 1'b0;
`else
        ev = 1'b1;
`endif
      end
    end else begin
      ei = 2'(DATA_BYTES - m_remaining + 1);
      m_remaining--;
      ea = is_hdr;
      ev = 1'b1;
    end
    ep = m_pt;
  endtask

  // One serial bit; on the last bit of a byte, byte_valid must appear exactly
  // SYNC_STAGES+1 clk_50 edges after clk_2 rises (sync + tick cycle + register).
  task automatic send_bit(input logic b, input logic last, input logic ev);
    @(negedge clk_50);
    serial_data = b;
    repeat (3) @(negedge clk_50);
    clk_2 = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk_50);
      #1;
      if (last) check("bv_latency", {31'd0, byte_valid}, {31'd0, (ev && (k == int'(SYNC_STAGES) + 1))});
    end
    @(negedge clk_50);
    clk_2 = 1'b0;
    repeat (12) @(negedge clk_50);
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic ev, ea, ep;
    logic [1:0] ei;
    ev_t got;
    model_byte(b, ev, ea, ep, ei);
    for (int i = 7; i >= 0; i--) send_bit(b[i], (i == 0), ev);
    check("byte_out", {24'd0, byte_out}, {24'd0, b});
    check("bv_count", evq.size(), ev ? 1 : 0);
    if (evq.size() > 0) begin
      got = evq.pop_front();
      check("ev_byte", {24'd0, got.b}, {24'd0, b});
      check("a5_or_c3", {31'd0, got.a5}, {31'd0, ea});
      check("pkt_temp", {31'd0, got.pt}, {31'd0, ep});
      check("byte_idx", {30'd0, got.idx}, {30'd0, ei});
    end
  endtask

  task automatic send_partial(input int n);
    for (int i = 0; i < n; i++) send_bit(1'($urandom), 1'b0, 1'b0);
    m_bits += n;
  endtask

  task automatic drop_ena();
    int fe0;
    int exp_fe;
    exp_fe = ((m_bits != 0) || (m_remaining != 0)) ? 1 : 0;
    fe0 = fe_cnt;
    @(negedge clk_50);
    data_ena = 1'b0;
    repeat (10) @(negedge clk_50);
    data_ena = 1'b1;
    repeat (10) @(negedge clk_50);
    check("frame_err_count", fe_cnt - fe0, exp_fe);
    check("no_bv_on_drop", evq.size(), 0);
    m_bits      = 0;
    m_remaining = 0;
  endtask

  initial begin
    int fe0;
    int op;
    int sel;
    logic [7:0] rb;

    reset_n     = 1'b0;
    clk_2       = 1'b0;
    serial_data = 1'b0;
    data_ena    = 1'b0;
    repeat (4) @(negedge clk_50);
    check("rst_byte_out", {24'd0, byte_out}, 0);
    check("rst_byte_valid", {31'd0, byte_valid}, 0);
    check("rst_a5_or_c3", {31'd0, a5_or_c3}, 0);
    check("rst_pkt_temp", {31'd0, pkt_temp}, 0);
    check("rst_byte_idx", {30'd0, byte_idx}, 0);
    check("rst_frame_err", {31'd0, frame_err}, 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk_50);
    data_ena = 1'b1;
    repeat (10) @(negedge clk_50);

    // Temperature header, then its payload
    fe0 = fe_cnt;
    send_byte(8'hA5);
    send_byte(8'h11);
    send_byte(8'h22);

    // Check packet, full length, clean
    send_byte(8'hC3);
    send_byte(8'h12);
    send_byte(8'h34);
    check("no_frame_err_full_pkts", fe_cnt - fe0, 0);

    // Short payload with a pending partial byte: one pulse, then recover
    send_byte(8'hA5);
    send_partial(3);
    drop_ena();
    send_byte(8'hA5);
    send_byte(8'h5A);
    send_byte(8'h00);

    // Non-header in idle
    send_byte(8'h7E);

    // Header value as payload
    send_byte(8'hA5);
    send_byte(8'hA5);
    send_byte(8'h00);

    // Reset mid-byte
    fe0 = fe_cnt;
    send_partial(5);
    reset_n = 1'b0;
    @(posedge clk_50);
    #1;
    check("midrst_byte_out", {24'd0, byte_out}, 0);
    check("midrst_byte_valid", {31'd0, byte_valid}, 0);
    check("midrst_a5_or_c3", {31'd0, a5_or_c3}, 0);
    check("midrst_pkt_temp", {31'd0, pkt_temp}, 0);
    check("midrst_byte_idx", {30'd0, byte_idx}, 0);
    @(negedge clk_50);
    reset_n = 1'b1;
    m_bits      = 0;
    m_remaining = 0;
    m_pt        = 1'b0;
    repeat (10) @(negedge clk_50);
    check("midrst_no_frame_err", fe_cnt - fe0, 0);
    check("midrst_no_bv", evq.size(), 0);
    send_byte(8'h55);

    // Randomized traffic
    for (int r = 0; r < 14; r++) begin
      op = $urandom_range(0, 9);
      if (op < 7) begin
        sel = $urandom_range(0, 3);
        rb  = (sel == 0) ? H_TEMP : (sel == 1) ? H_CHECK : 8'($urandom);
        send_byte(rb);
      end else if (op < 9) begin
        send_partial($urandom_range(1, 7));
        drop_ena();
      end else begin
        drop_ena();
      end
    end
    drop_ena();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/rx_byte_asm_50.md
Name: rx_byte_asm_50

Overview:
- Serial front end of the receive path, directly upstream of the clk_50 control block.
- Samples a slow serial line (bit clock clk_2, data, enable) using clk_50 and assembles bits MSB-first into bytes.
- Flags header bytes (0xA5 temperature, 0xC3 check) and emits one-cycle byte strobes.
- Its outputs drive the a5_or_c3 and data_ena inputs of the downstream control FSM and the FIFO data bus.

Parameters:
- SYNC_STAGES, 2, flops per synchronizer chain on clk_2, serial_data and data_ena (minimum 2).
- HDR_TEMP, 8'hA5, temperature-packet header byte.
- HDR_CHECK, 8'hC3, check-packet header byte.
- DATA_BYTES, 2, payload bytes expected after each header.

Ports:
- clk_50  input  1  system clock, 50 MHz; the only clock.
- reset_n  input  1  synchronous, active-low reset.
- clk_2  input  1  serial bit clock, treated as asynchronous data; synchronized internally.
- serial_data  input  1  serial bit, valid on clk_2 rising edge.
- data_ena  input  1  serial frame enable, async; high while bits are being sent.
- byte_out  output  8  last assembled byte; held until the next byte completes.
- byte_valid  output  1  one-cycle strobe; byte_out is new.
- a5_or_c3  output  1  high with byte_valid when byte_out equals HDR_TEMP or HDR_CHECK.
- pkt_temp  output  1  level: the most recent header was HDR_TEMP.
- byte_idx  output  2  0 = header, 1..DATA_BYTES = payload position of byte_out.
- frame_err  output  1  one-cycle strobe; partial byte discarded or payload short.

Behaviour:
- Reset: all outputs 0, bit_cnt 0, shift register 0, state IDLE, synchronizers cleared. Reset is sampled only on a clk_50 rising edge. Asserting reset mid-byte discards everything with no frame_err.
- Sync and edge detect:
  - Each async input passes through SYNC_STAGES flops.
  - tick = synced clk_2 is 1 and its previous-cycle value is 0.
  - ena_s = synced data_ena.
- Bit capture, on a tick with ena_s = 1:
  - sh <= {sh[6:0], serial_data_s}; bit_cnt <= bit_cnt + 1 (3-bit, wraps 7 -> 0).
  - On the tick where bit_cnt == 7, the next clk_50 cycle has byte_out = completed byte, byte_valid = 1, and a5_or_c3 / byte_idx valid.
  - Latency: byte_valid rises exactly 1 clk_50 cycle after the cycle the 8th tick is detected.
- Ticks with ena_s = 0 are ignored.
- Falling edge of ena_s with bit_cnt != 0: bit_cnt <= 0 and frame_err pulses the following cycle.
- Packet FSM (advances only on byte completion):
  - IDLE:
    - Header byte -> HDR, then PAYLOAD; byte_idx = 0; pkt_temp <= (byte == HDR_TEMP).
    - Any other byte: byte_idx = 0 and a5_or_c3 = 0; the byte is still output.
  - PAYLOAD:
    - byte_idx increments 1..DATA_BYTES.
    - After DATA_BYTES bytes -> IDLE.
    - A payload byte equal to a header value is data: a5_or_c3 is still asserted, but the FSM does not restart.
  - ena_s falling in PAYLOAD before DATA_BYTES bytes: frame_err pulses once and the FSM returns to IDLE. If a partial byte is also pending, frame_err is still a single pulse.
- Simultaneous byte completion and ena_s fall in the same cycle: the byte completes normally; the falling edge then checks the updated counters.
- byte_valid never asserts on two consecutive cycles, since ticks are ≥ 25 cycles apart.

Optional Feature:
- Macro: RX_HDR_FILTER_EN.
- Defined: byte_valid is suppressed for non-header bytes received in IDLE. Only headers and their payloads reach downstream, and byte_out still updates.
- Undefined: every completed byte produces byte_valid, as described above.

Decomposition:
- Package rx_pkg:
  - HDR_TEMP_C / HDR_CHECK_C constants.
  - typedef enum {IDLE, PAYLOAD} rx_pkt_state_t.
  - typedef logic [7:0] rx_byte_t.
- Sub-module rx_sync_edge: parameterized SYNC_STAGES synchronizer plus rising/falling edge outputs. It is instantiated for clk_2 and data_ena; serial_data uses the synchronizer only.

Test Plan:
- Reset, then ena high and send bits 1,0,1,0,0,1,0,1 -> one byte_valid, byte_out = 8'hA5, a5_or_c3 = 1, pkt_temp = 1, byte_idx = 0, latency 1 cycle after the 8th tick.
- Send C3, 12, 34 -> byte_idx 0, 1, 2; pkt_temp = 0; after the 3rd byte the FSM returns to IDLE; no frame_err.
- Send A5 then drop ena after 3 bits of the payload -> exactly one frame_err pulse, no byte_valid for the partial byte; the next A5 is accepted as a header.
- Send 7E in IDLE -> byte_valid = 1, a5_or_c3 = 0, byte_idx = 0. With RX_HDR_FILTER_EN: no byte_valid, byte_out = 7E.
- Send A5, A5, 00 -> the second A5 is payload (byte_idx = 1, a5_or_c3 = 1); 00 has byte_idx = 2.
- Assert reset_n = 0 for one cycle after 5 bits -> all outputs 0, no frame_err; a subsequent full byte 55 assembles correctly.
